dmem_arbiter: RTL

Two-port arbiter that shares the single-port synchronous data memory (dmem) between requester 0 (processor load/store unit, MAR path) and requester 1 (secondary master, e.g. display refresh or DMA engine).
- Grants ownership round-robin, with optional locked bursts capped by a hold counter to prevent starvation.
- Drives the dmem port and returns read data with fixed one-cycle latency.
- Sits between the bus-side MAR/MDR logic and the dmem array.

---
 rtl/dmem_arbiter.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares one single-port synchronous data memory between two
//            requesters. Port 0 is the processor load/store path and port 1
//            is a secondary master such as display refresh or DMA.
//            Ownership is handed out round-robin. An owner may lock the
//            memory for a burst. While the other port is waiting, a burst
//            is capped at MAXHOLD accesses.
//            Read data returns exactly one cycle after the grant. An access
//            whose address lies outside the dmem window is still granted,
//            but it never reaches the memory and reports err instead.
// Ports    : clk, reset           clock, asynchronous active-high reset
//            req/lock/we/addr/wdata{0,1}
//                                 requester inputs, held until granted
//            gnt{0,1}             access issued this cycle (combinational)
//            rvalid/err/rdata{0,1}
//                                 read return / range error, one cycle later
//            mem_en/mem_we/mem_addr/mem_wdata
//                                 dmem command port (word addressed)
//            mem_rdata            dmem read data, cycle after a read strobe
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int DBITS        = 32,
    parameter int DMEMADDRBITS = 16,
    parameter int DMEMWORDBITS = 2,
    parameter int MAXHOLD      = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,

    input  logic                                 req0,
    input  logic                                 lock0,
    input  logic                                 we0,
    input  logic [DBITS-1:0]                     addr0,
    input  logic [DBITS-1:0]                     wdata0,
    output logic                                 gnt0,
    output logic                                 rvalid0,
    output logic                                 err0,
    output logic [DBITS-1:0]                     rdata0,

    input  logic                                 req1,
    input  logic                                 lock1,
    input  logic                                 we1,
    input  logic [DBITS-1:0]                     addr1,
    input  logic [DBITS-1:0]                     wdata1,
    output logic                                 gnt1,
    output logic                                 rvalid1,
    output logic                                 err1,
    output logic [DBITS-1:0]                     rdata1,

    output logic                                 mem_en,
    output logic                                 mem_we,
    output logic [DMEMADDRBITS-DMEMWORDBITS-1:0] mem_addr,
    output logic [DBITS-1:0]                     mem_wdata,
    input  logic [DBITS-1:0]                     mem_rdata
);

    localparam int c_IDX_W = DMEMADDRBITS - DMEMWORDBITS;
    localparam int c_CNT_W = $clog2(MAXHOLD + 1);
    // hold_cnt + 1 >= MAXHOLD  <=>  hold_cnt >= MAXHOLD - 1
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(MAXHOLD - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_MAX  = c_CNT_W'(MAXHOLD);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_rr;          // last owner; the other port wins a tie
    logic                 w_rr_nxt;
    logic [c_CNT_W-1:0]   r_hold_cnt;
    logic [c_CNT_W-1:0]   w_hold_nxt;

    logic                 r_rvalid0;
    logic                 r_rvalid1;
    logic                 r_err0;
    logic                 r_err1;
    logic                 w_rvalid0_nxt;
    logic                 w_rvalid1_nxt;
    logic                 w_err0_nxt;
    logic                 w_err1_nxt;

    // ------------------------------------------------------------------
    // Signals of the current owner. When idle, w_sel = 0, but nothing is
    // issued, because w_own gates the grant.
    // ------------------------------------------------------------------
    logic                 w_own;
    logic                 w_sel;
    logic                 w_req_sel;
    logic                 w_lock_sel;
    logic                 w_we_sel;
    logic [DBITS-1:0]     w_addr_sel;
    logic [DBITS-1:0]     w_wdata_sel;
    logic                 w_other_req;
    logic                 w_in_range;
    logic                 w_gnt;
    logic                 w_hold_last;
    logic                 w_release;
    logic                 w_unused_bits;

    assign w_own       = (r_state == S_OWN0) || (r_state == S_OWN1);
    assign w_sel       = (r_state == S_OWN1);
    assign w_req_sel   = w_sel ? req1   : req0;
    assign w_lock_sel  = w_sel ? lock1  : lock0;
    assign w_we_sel    = w_sel ? we1    : we0;
    assign w_addr_sel  = w_sel ? addr1  : addr0;
    assign w_wdata_sel = w_sel ? wdata1 : wdata0;
    assign w_other_req = w_sel ? req0   : req1;

    // Address bits above the dmem window must be zero. When the window
    // spans the whole bus, every address is in range.
    generate
        if (DBITS > DMEMADDRBITS) begin : g_range_chk
            assign w_in_range = (w_addr_sel[DBITS-1:DMEMADDRBITS] == '0);
        end else begin : g_range_all
            assign w_in_range = 1'b1;
        end
    endgenerate

    // The byte-offset bits select nothing in a word-wide memory.
    assign w_unused_bits = ^w_addr_sel[DMEMWORDBITS-1:0];

    assign w_gnt = w_own && w_req_sel;
    assign gnt0  = w_gnt && !w_sel;
    assign gnt1  = w_gnt &&  w_sel;

    // An out-of-range access is granted, so the requester can move on,
    // but it never strobes the memory.
    assign mem_en    = w_gnt && w_in_range;
    assign mem_we    = w_gnt && w_in_range && w_we_sel;
    assign mem_addr  = w_gnt ? w_addr_sel[DMEMADDRBITS-1:DMEMWORDBITS]
                             : {c_IDX_W{1'b0}};
    assign mem_wdata = w_gnt ? w_wdata_sel : {DBITS{1'b0}};

    assign w_hold_last = (r_hold_cnt >= c_HOLD_LAST);

    // Give up ownership in three cases: the request went away (done or
    // abandoned), an unlocked access was issued, or the burst used up its
    // share while the other port waits.
    assign w_release = w_own &&
                       (!w_req_sel ||
                        (w_gnt && !w_lock_sel) ||
                        (w_gnt && w_hold_last && w_other_req));

    // ------------------------------------------------------------------
    // Next-state / ownership logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr;
        w_hold_nxt  = r_hold_cnt;
        case (r_state)
            S_IDLE: begin
                w_hold_nxt = '0;
                if (req0 && req1) begin
                    w_state_nxt = r_rr ? S_OWN0 : S_OWN1;
                end else if (req0) begin
                    w_state_nxt = S_OWN0;
                end else if (req1) begin
                    w_state_nxt = S_OWN1;
                end
            end
            S_OWN0, S_OWN1: begin
                if (w_release) begin
                    // A waiting port takes over directly, with no idle bubble.
                    w_hold_nxt  = '0;
                    w_rr_nxt    = w_sel;
                    if (w_other_req) begin
                        w_state_nxt = w_sel ? S_OWN0 : S_OWN1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_gnt && (r_hold_cnt != c_HOLD_MAX)) begin
                    w_hold_nxt = r_hold_cnt + c_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_hold_nxt  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Return pipeline: reads get rvalid next cycle, and out-of-range
    // accesses get err next cycle. At most one port is granted per cycle,
    // so the two rvalids are mutually exclusive.
    // ------------------------------------------------------------------
    always_comb begin
        w_rvalid0_nxt = gnt0 && !we0;
        w_rvalid1_nxt = gnt1 && !we1;
        w_err0_nxt    = gnt0 && !w_in_range;
        w_err1_nxt    = gnt1 && !w_in_range;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_rr       <= 1'b1;
            r_hold_cnt <= '0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_err0     <= 1'b0;
            r_err1     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr       <= w_rr_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_rvalid0  <= w_rvalid0_nxt;
            r_rvalid1  <= w_rvalid1_nxt;
            r_err0     <= w_err0_nxt;
            r_err1     <= w_err1_nxt;
        end
    end

    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign err0    = r_err0;
    assign err1    = r_err1;

    // Memory data is forwarded only for a valid in-range read. Otherwise
    // the outputs stay at zero, whatever mem_rdata holds.
    assign rdata0 = (r_rvalid0 && !r_err0) ? mem_rdata : {DBITS{1'b0}};
    assign rdata1 = (r_rvalid1 && !r_err1) ? mem_rdata : {DBITS{1'b0}};

endmodule
`default_nettype wire
